// File: rtl/bp_update_queue_pkg.sv
// Shared parameters and entry record for the branch-predictor update queue.
package bp_update_queue_pkg;

  localparam int XLEN        = 32;
  localparam int BPQ_DEPTH   = 4;
  localparam int BPQ_PTR_W   = 2;
  localparam int BPQ_ENTRY_W = XLEN + 2;

  typedef struct packed {
    logic [XLEN-1:0] inst_addr;
    logic            jump;
    logic            correct;
  } bpq_entry_t;

  // Correctness is resolved once, at push, so the drain side only forwards bits.
  function automatic bpq_entry_t make_entry(input logic [XLEN-1:0] addr,
                                            input logic pred,
                                            input logic jump);
    bpq_entry_t e;
    e.inst_addr = addr;
    e.jump      = jump;
    e.correct   = (pred == jump);
    return e;
  endfunction

endpackage

// File: rtl/bp_update_queue_if.sv
// ROB-side commit lanes and predictor-side update bus of the update queue.
interface bp_update_queue_if;
  import bp_update_queue_pkg::*;

  logic            rob_bpq_valid0;
  logic            rob_bpq_valid1;
  logic [XLEN-1:0] rob_bpq_inst_addr0;
  logic [XLEN-1:0] rob_bpq_inst_addr1;
  logic            rob_bpq_pred0;
  logic            rob_bpq_pred1;
  logic            rob_bpq_jump0;
  logic            rob_bpq_jump1;
  logic            bpq_rob_ready;

  logic            rob_bp_enable;
  logic [XLEN-1:0] rob_bp_inst_addr;
  logic            rob_bp_jump;
  logic            rob_bp_correct;

  logic [XLEN-1:0]    bpq_mispred_cnt;
  logic [BPQ_PTR_W:0] bpq_count;

  modport master (
    output rob_bpq_valid0, rob_bpq_valid1, rob_bpq_inst_addr0, rob_bpq_inst_addr1,
           rob_bpq_pred0, rob_bpq_pred1, rob_bpq_jump0, rob_bpq_jump1,
    input  bpq_rob_ready, rob_bp_enable, rob_bp_inst_addr, rob_bp_jump,
           rob_bp_correct, bpq_mispred_cnt, bpq_count
  );

  modport slave (
    input  rob_bpq_valid0, rob_bpq_valid1, rob_bpq_inst_addr0, rob_bpq_inst_addr1,
           rob_bpq_pred0, rob_bpq_pred1, rob_bpq_jump0, rob_bpq_jump1,
    output bpq_rob_ready, rob_bp_enable, rob_bp_inst_addr, rob_bp_jump,
           rob_bp_correct, bpq_mispred_cnt, bpq_count
  );

endinterface

// File: rtl/bpq_fifo_2w1r.sv
// Two-write / one-read circular buffer; pops the head every cycle it is non-empty.
module bpq_fifo_2w1r
  import bp_update_queue_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push0,
  input  logic               push1,
  input  bpq_entry_t         din0,
  input  bpq_entry_t         din1,
  output bpq_entry_t         head,
  output logic               empty,
  output logic [BPQ_PTR_W:0] count
);

  bpq_entry_t         mem [BPQ_DEPTH];
  logic [BPQ_PTR_W:0] wptr;
  logic [BPQ_PTR_W:0] rptr;
  logic [BPQ_PTR_W:0] wptr_next1;
  logic [BPQ_PTR_W:0] push_num;
  logic               pop;

  assign wptr_next1 = wptr + (BPQ_PTR_W+1)'(1);
  assign push_num   = (BPQ_PTR_W+1)'(push0) + (BPQ_PTR_W+1)'(push1);
  assign count      = wptr - rptr;
  assign empty      = (count == '0);
  assign pop        = !empty;
  assign head       = mem[rptr[BPQ_PTR_W-1:0]];

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push0) mem[wptr[BPQ_PTR_W-1:0]]       <= din0;
    if (push1) mem[wptr_next1[BPQ_PTR_W-1:0]] <= din1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + push_num;
      if (pop) rptr <= rptr + (BPQ_PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/bp_update_queue.sv
// Serializes up to two committed branches per cycle into one predictor update per cycle.
module bp_update_queue
  import bp_update_queue_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  bp_update_queue_if.slave  bus
);

  bpq_entry_t         entry0;
  bpq_entry_t         entry1;
  bpq_entry_t         head;
  logic               empty;
  logic [BPQ_PTR_W:0] count;
  logic [BPQ_PTR_W:0] free_slots;
  logic               ready;
  logic               push0;
  logic               push1;
  logic [XLEN-1:0]    mispred_cnt;

  assign entry0 = make_entry(bus.rob_bpq_inst_addr0, bus.rob_bpq_pred0, bus.rob_bpq_jump0);
  assign entry1 = make_entry(bus.rob_bpq_inst_addr1, bus.rob_bpq_pred1, bus.rob_bpq_jump1);

  // Ready depends only on the registered occupancy, never on this cycle's valids.
  assign free_slots = (BPQ_PTR_W+1)'(BPQ_DEPTH) - count;
  assign ready      = (free_slots >= (BPQ_PTR_W+1)'(2));

  assign push0 = ready && bus.rob_bpq_valid0;
  assign push1 = ready && bus.rob_bpq_valid0 && bus.rob_bpq_valid1;

  bpq_fifo_2w1r u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push0 (push0),
    .push1 (push1),
    .din0  (entry0),
    .din1  (entry1),
    .head  (head),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispred_cnt <= '0;
    end else if (!empty && !head.correct) begin
      mispred_cnt <= mispred_cnt + XLEN'(1);
    end
  end

  assign bus.bpq_rob_ready    = ready;
  assign bus.rob_bp_enable    = !empty;
  assign bus.rob_bp_inst_addr = head.inst_addr;
  assign bus.rob_bp_jump      = head.jump;
  assign bus.rob_bp_correct   = head.correct;
  assign bus.bpq_mispred_cnt  = mispred_cnt;
  assign bus.bpq_count        = count;

`ifndef SYNTHESIS
  valid1_needs_valid0: assert property (@(posedge clk) disable iff (!rst_n)
    bus.rob_bpq_valid1 |-> bus.rob_bpq_valid0);
  push_needs_ready: assert property (@(posedge clk) disable iff (!rst_n)
    bus.rob_bpq_valid0 |-> ready);
`endif

endmodule

// File: doc/bp_update_queue.md
# bp_update_queue

Serializes committed branch outcomes from the ROB into the single-port update interface of the branch predictor. The ROB commits up to two branches per cycle (lane 0 older than lane 1). This block computes per-branch prediction correctness, buffers records in order in a small FIFO, and presents exactly one predictor update per cycle. It also keeps a running mispredict count for accuracy reporting.

## Interface
- `BPQ_DEPTH`, 4: FIFO entries; power of two, at least 2.
- `BPQ_PTR_W`, 2: log2(`BPQ_DEPTH`).

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rob_bpq_valid0` / `rob_bpq_valid1`  in  1 each  committed-branch strobe per lane; `valid1` implies `valid0`
- `rob_bpq_inst_addr0` / `rob_bpq_inst_addr1`  in  `XLEN`  branch instruction address
- `rob_bpq_pred0` / `rob_bpq_pred1`  in  1  prediction made at fetch (1 = taken)
- `rob_bpq_jump0` / `rob_bpq_jump1`  in  1  resolved outcome (1 = taken)
- `bpq_rob_ready`  out  1  high when at least 2 entries are free
- `rob_bp_enable`  out  1  predictor update strobe
- `rob_bp_inst_addr`  out  `XLEN`  update address
- `rob_bp_jump`  out  1  resolved outcome
- `rob_bp_correct`  out  1  prediction matched outcome
- `bpq_mispred_cnt`  out  `XLEN`  total mispredicts drained, wraps modulo 2^`XLEN`
- `bpq_count`  out  `BPQ_PTR_W`+1  current occupancy

## Operation
- Entry fields: `{inst_addr, jump, correct}`, where `correct = (pred == jump)` is computed at push.
- Push:
  - Pushes occur only when `bpq_rob_ready` is high.
  - If the ROB asserts a valid while ready is low, that is a protocol violation. The block ignores the push and flags it with a simulation assertion.
  - Lane 0 is written at `wptr`, lane 1 at `wptr+1`. `wptr` advances by the number of valid lanes (0, 1 or 2).
  - `valid1` without `valid0` is illegal and is asserted against.
- Pop:
  - When the queue is non-empty, the head entry drives the `rob_bp_*` outputs combinationally and `rob_bp_enable` is 1.
  - The head is consumed at the next edge and `rptr` advances by 1. The predictor always accepts, so there is no backpressure.
- Mispredict counter: increments by 1 at every edge where `rob_bp_enable` is 1 and `rob_bp_correct` is 0.
- Occupancy:
  - Pointers are `BPQ_PTR_W`+1 bits wide, and `count = wptr - rptr`.
  - Empty when `count` is 0; full when `count` equals `BPQ_DEPTH`.
  - Next count = count + pushes − pop. Pop is 1 if count > 0.
- Simultaneous push and pop:
  - Legal in the same cycle. When count is 0, a pop does not occur.
  - An entry pushed at edge k is first visible at the head after edge k. There is no same-cycle bypass.
- Ready: `bpq_rob_ready = (BPQ_DEPTH - count) >= 2`. Ready is computed from the registered count only, so there is no combinational path from valid to ready.
- No flush input: committed branches are architectural and are never discarded.

## Timing
- Reset (asynchronous, `rst_n` low):
  - `wptr`, `rptr` and `bpq_mispred_cnt` go to 0.
  - The FIFO storage is not reset.
  - Outputs during reset: `rob_bp_enable` 0, `bpq_rob_ready` 1, `bpq_count` 0.
  - `rob_bp_inst_addr`, `rob_bp_jump` and `rob_bp_correct` are don't-care while enable is 0, but must not be X when `rob_bp_enable` is 1.
- Reset asserted mid-stream: all queued entries are lost and no update is issued after `rst_n` falls. Operation resumes from the first edge after `rst_n` rises.
- Latency: push at edge k, update visible during cycle k+1, consumed at edge k+1.
- Throughput:
  - Sustained input of 1 branch/cycle: never stalls.
  - Sustained input of 2 branches/cycle: the queue fills; ready drops when ≤1 entry is free and reasserts after drain.
- Pointer wrap: indices use the low `BPQ_PTR_W` bits. Full and empty are distinguished by the extra MSB.

## Structure
- Shared package/include (`global_params.v`):
  - `XLEN` (already present).
  - Add `BPQ_DEPTH`, `BPQ_PTR_W` defaults.
  - Add the entry field width macro `BPQ_ENTRY_W` = `XLEN`+2.
- One natural sub-module, `bpq_fifo_2w1r`: 2-write/1-read circular buffer with count and pointers. The top level adds correctness compute, ready logic and the mispredict counter.

## Test plan
- Single push: reset, one edge with `valid0`=1, addr `0x1000`, pred 1, jump 0. Next cycle: enable 1, addr `0x1000`, jump 0, correct 0. The following edge: `bpq_mispred_cnt`=1 and enable returns to 0.
- Dual push ordering: lane0 addr `0x20` (pred 0, jump 0), lane1 addr `0x24` (pred 1, jump 1) in one edge → updates `0x20` then `0x24` on consecutive cycles, both correct=1, mispred_cnt stays 0.
- Fill/ready: 2 dual pushes on back-to-back edges with `BPQ_DEPTH`=4 → after the 2nd edge count=3 (one popped), ready=0. Ready returns to 1 after one more cycle (count=2). All 4 addresses appear in order.
- Wrap-around: 20 random single/dual pushes respecting ready → the update address sequence equals the push sequence exactly, and mispred_cnt equals the reference-model count.
- Mid-stream reset: 3 entries queued, pull `rst_n` low asynchronously between edges → enable drops immediately, and count=0, ready=1, mispred_cnt=0. After release, a new push of `0x40` is the first update seen.
- Illegal input: `valid1`=1 with `valid0`=0 → assertion fires, queue unchanged.
